// File: rtl/prog_loader_pkg.sv
// Shared command codes, FSM state encoding and default memory depths for the program loader.
// The CSUM state exists only when PROG_LOADER_CHECKSUM_EN is defined.
package prog_loader_pkg;

    localparam int IMEM_WORDS_DEF = 256;
    localparam int DMEM_BYTES_DEF = 32;

    localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'h02;
    localparam logic [7:0] CMD_START     = 8'h03;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BASE,
        S_COUNT,
        S_DATA,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_RUN,
        S_ERR
    } state_e;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Shifts payload bytes into a little-endian 32-bit word; done_o marks the byte that completes a word.
// word_o already includes the incoming byte so the caller can capture it on that same edge.
module byte_packer
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    logic [23:0] shreg_q, shreg_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            shreg_d = '0;
            cnt_d   = '0;
        end else if (en_i) begin
            shreg_d = {byte_i, shreg_q[23:8]};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    assign word_o = {byte_i, shreg_q};
    assign done_o = en_i && (cnt_q == 2'd3);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses CMD/BASE/COUNT/payload frames into imem/dmem writes, then starts the CPU.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing payload-sum byte on every load frame.
//
// state   | meaning
// IDLE    | waiting for a command byte
// BASE    | capturing base address / word index
// COUNT   | capturing length (0 means 256)
// DATA    | payload bytes, writes issued as they arrive
// CSUM    | trailing checksum byte (checksum builds only)
// RUN     | CPU started, input closed until reset
// ERR     | protocol error, input drained until reset
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int IMEM_WORDS = IMEM_WORDS_DEF,
    parameter int DMEM_BYTES = DMEM_BYTES_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [7:0]                    in_data_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    output logic                          imem_we_o,
    output logic [$clog2(IMEM_WORDS)-1:0] imem_addr_o,
    output logic [31:0]                   imem_data_o,
    output logic                          dmem_we_o,
    output logic [$clog2(DMEM_BYTES)-1:0] dmem_addr_o,
    output logic [7:0]                    dmem_data_o,
    output logic                          start_o,
    output logic                          err_o,
    output logic [15:0]                   words_loaded_o
);

    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_BYTES);

    state_e               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
    logic [31:0]          imem_data_q, imem_data_d;
    logic                 dmem_we_q, dmem_we_d;
    logic [DMEM_AW-1:0]   dmem_addr_q, dmem_addr_d;
    logic [7:0]           dmem_data_q, dmem_data_d;
    logic                 start_q, start_d;
    logic                 err_q, err_d;
    logic [15:0]          words_q, words_d;
    logic                 is_imem_q, is_imem_d;
    logic [7:0]           base_q, base_d;
    logic [10:0]          bytes_left_q, bytes_left_d;
    logic [9:0]           idx_q, idx_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    logic        xfer;
    logic [8:0]  n_cnt;
    logic        pk_clr, pk_en, pk_done;
    logic [31:0] pk_word;

    assign xfer  = in_valid_i & in_ready_q;
    assign n_cnt = (in_data_i == 8'd0) ? 9'd256 : {1'b0, in_data_i};

    byte_packer u_packer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (pk_clr),
        .en_i   (pk_en),
        .byte_i (in_data_i),
        .word_o (pk_word),
        .done_o (pk_done)
    );

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_data_d  = imem_data_q;
        dmem_we_d    = 1'b0;
        dmem_addr_d  = dmem_addr_q;
        dmem_data_d  = dmem_data_q;
        start_d      = start_q;
        err_d        = err_q;
        words_d      = words_q;
        is_imem_d    = is_imem_q;
        base_d       = base_q;
        bytes_left_d = bytes_left_q;
        idx_d        = idx_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        pk_clr       = 1'b0;
        pk_en        = 1'b0;

        case (state_q)
            S_IDLE: if (xfer) begin
                pk_clr = 1'b1;
                if (in_data_i == CMD_LOAD_IMEM || in_data_i == CMD_LOAD_DMEM) begin
                    is_imem_d = (in_data_i == CMD_LOAD_IMEM);
                    state_d   = S_BASE;
                end else if (in_data_i == CMD_START) begin
                    start_d = 1'b1;
                    state_d = S_RUN;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_BASE: if (xfer) begin
                base_d  = in_data_i;
                state_d = S_COUNT;
            end
            S_COUNT: if (xfer) begin
                bytes_left_d = is_imem_q ? {n_cnt, 2'b00} : {2'b00, n_cnt};
                idx_d        = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d       = '0;
`endif
                state_d      = S_DATA;
            end
            S_DATA: if (xfer) begin
                idx_d        = idx_q + 10'd1;
                bytes_left_d = bytes_left_q - 11'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum_d       = csum_q + in_data_i;
`endif
                if (is_imem_q) begin
                    pk_en = 1'b1;
                    if (pk_done) begin
                        imem_we_d   = 1'b1;
                        imem_addr_d = base_q[IMEM_AW-1:0] + idx_q[IMEM_AW+1:2];
                        imem_data_d = pk_word;
                        words_d     = words_q + 16'd1;
                    end
                end else begin
                    dmem_we_d   = 1'b1;
                    dmem_addr_d = base_q[DMEM_AW-1:0] + idx_q[DMEM_AW-1:0];
                    dmem_data_d = in_data_i;
                end
                if (bytes_left_q == 11'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    state_d = S_IDLE;
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: if (xfer) begin
                if (in_data_i == csum_q) begin
                    state_d = S_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
`endif
            S_RUN: ;
            S_ERR: ;
            default: state_d = S_IDLE;
        endcase

        // Ready is registered, so it must be derived from the next state.
        in_ready_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_data_q  <= '0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_data_q  <= '0;
            start_q      <= 1'b0;
            err_q        <= 1'b0;
            words_q      <= '0;
            is_imem_q    <= 1'b0;
            base_q       <= '0;
            bytes_left_q <= '0;
            idx_q        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_data_q  <= imem_data_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_data_q  <= dmem_data_d;
            start_q      <= start_d;
            err_q        <= err_d;
            words_q      <= words_d;
            is_imem_q    <= is_imem_d;
            base_q       <= base_d;
            bytes_left_q <= bytes_left_d;
            idx_q        <= idx_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign in_ready_o     = in_ready_q;
    assign imem_we_o      = imem_we_q;
    assign imem_addr_o    = imem_addr_q;
    assign imem_data_o    = imem_data_q;
    assign dmem_we_o      = dmem_we_q;
    assign dmem_addr_o    = dmem_addr_q;
    assign dmem_data_o    = dmem_data_q;
    assign start_o        = start_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: frames push expected memory writes, a negedge monitor pops and compares them.
// Checksum frames and the bad-checksum case are exercised when PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready_o, imem_we_o, dmem_we_o, start_o, err_o;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_data_o;
    logic [4:0]  dmem_addr_o;
    logic [7:0]  dmem_data_o;
    logic [15:0] words_loaded_o;

    prog_loader dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .in_data_i      (in_data),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready_o),
        .imem_we_o      (imem_we_o),
        .imem_addr_o    (imem_addr_o),
        .imem_data_o    (imem_data_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_data_o    (dmem_data_o),
        .start_o        (start_o),
        .err_o          (err_o),
        .words_loaded_o (words_loaded_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [15:0] words;
    } iexp_t;
    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } dexp_t;

    iexp_t       iq[$];
    dexp_t       dq[$];
    logic [7:0]  pl[$];
    logic [15:0] words_exp = 16'd0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Write monitor: every strobe must match the oldest outstanding expectation.
    iexp_t ie;
    dexp_t de;
    always @(negedge clk) begin
        if (!rst) begin
            if (imem_we_o !== 1'b0) begin
                if (iq.size() == 0) check("imem_unexpected_we", imem_we_o, 1'b0);
                else begin
                    ie = iq.pop_front();
                    check("imem_addr", imem_addr_o, ie.addr);
                    check("imem_data", imem_data_o, ie.data);
                    check("imem_words", words_loaded_o, ie.words);
                end
            end
            if (dmem_we_o !== 1'b0) begin
                if (dq.size() == 0) check("dmem_unexpected_we", dmem_we_o, 1'b0);
                else begin
                    de = dq.pop_front();
                    check("dmem_addr", dmem_addr_o, de.addr);
                    check("dmem_data", dmem_data_o, de.data);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            check("ready_timeout", in_ready_o, 1'b1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] base, input logic [7:0] cnt);
        int         nb;
        logic [7:0] sum = 8'h00;
        nb = (cnt == 8'd0) ? 256 : int'(cnt);
        if (cmd == 8'h01) begin
            for (int w = 0; w < nb; w++) begin
                words_exp++;
                iq.push_back('{addr: base + 8'(w),
                               data: {pl[4*w+3], pl[4*w+2], pl[4*w+1], pl[4*w]},
                               words: words_exp});
            end
            nb = nb * 4;
        end else begin
            for (int i = 0; i < nb; i++)
                dq.push_back('{addr: 5'((int'(base) + i) % 32), data: pl[i]});
        end
        send(cmd);
        send(base);
        send(cnt);
        for (int i = 0; i < nb; i++) begin
            send(pl[i]);
            sum = sum + pl[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send(sum);
`endif
    endtask

    task automatic settle(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_imem_drained"}, iq.size(), 0);
        check({tag, "_dmem_drained"}, dq.size(), 0);
        check({tag, "_words"}, words_loaded_o, words_exp);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_ready"}, in_ready_o, 1'b0);
        check({tag, "_imem_we"}, imem_we_o, 1'b0);
        check({tag, "_dmem_we"}, dmem_we_o, 1'b0);
        check({tag, "_start"}, start_o, 1'b0);
        check({tag, "_err"}, err_o, 1'b0);
        check({tag, "_words"}, words_loaded_o, 16'd0);
        check({tag, "_imem_addr"}, imem_addr_o, 8'd0);
        check({tag, "_imem_data"}, imem_data_o, 32'd0);
        check({tag, "_dmem_addr"}, dmem_addr_o, 5'd0);
        check({tag, "_dmem_data"}, dmem_data_o, 8'd0);
    endtask

    task automatic reset_dut(input string tag);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk_reset(tag);
        iq.delete();
        dq.delete();
        words_exp = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check({tag, "_ready_rise"}, in_ready_o, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        @(negedge clk);
        check("por_ready_rise", in_ready_o, 1'b1);

        pl = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        frame(8'h01, 8'h00, 8'h02);
        settle("imem2");

        pl = '{8'h05, 8'h07};
        frame(8'h02, 8'h1F, 8'h02);
        settle("dmem_wrap");
        check("dmem_wrap_err", err_o, 1'b0);

        // Back-to-back frames, imem index wrapping past 255.
        pl.delete();
        for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
        frame(8'h01, 8'hFF, 8'h02);
        pl = '{8'hA1, 8'hB2, 8'hC3};
        frame(8'h02, 8'h10, 8'h03);
        settle("b2b");

        // COUNT 0 means 256; dmem overwrites itself modulo 32.
        pl.delete();
        for (int i = 0; i < 256; i++) pl.push_back(8'(i) ^ 8'h5A);
        frame(8'h02, 8'h03, 8'h00);
        settle("dmem256");

        pl.delete();
        for (int i = 0; i < 1024; i++) pl.push_back(8'($urandom));
        frame(8'h01, 8'h80, 8'h00);
        settle("imem256");

        check("pre_start", start_o, 1'b0);
        send(8'h03);
        @(negedge clk);
        check("start_rise", start_o, 1'b1);
        check("start_ready_low", in_ready_o, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_data  = 8'h01 + 8'(i);
            in_valid = 1'b1;
            @(negedge clk);
            check("run_ready_low", in_ready_o, 1'b0);
        end
        in_valid = 1'b0;
        check("run_start_held", start_o, 1'b1);
        check("run_err", err_o, 1'b0);
        settle("run");

        reset_dut("rst1");
        send(8'h7F);
        @(negedge clk);
        check("err_rise", err_o, 1'b1);
        check("err_ready", in_ready_o, 1'b1);
        send(8'h03);
        send(8'h01); send(8'h00); send(8'h01);
        send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
        settle("err_drain");
        check("err_no_start", start_o, 1'b0);
        check("err_sticky", err_o, 1'b1);

        reset_dut("rst2");
        send(8'h01); send(8'h05); send(8'h01); send(8'h11); send(8'h22);
        reset_dut("midframe");
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        frame(8'h01, 8'h07, 8'h01);
        settle("fresh");
        check("fresh_err", err_o, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        pl = '{8'h10, 8'h20};
        frame(8'h02, 8'h00, 8'h02);
        settle("csum_ok");
        check("csum_ok_err", err_o, 1'b0);
        dq.push_back('{addr: 5'd0, data: 8'h10});
        dq.push_back('{addr: 5'd1, data: 8'h20});
        send(8'h02); send(8'h00); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
        @(negedge clk);
        check("csum_bad_err", err_o, 1'b1);
        settle("csum_bad");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader for the five-stage RISC-V CPU. It accepts a framed command stream over a valid/ready byte interface and writes instruction memory (256 × 32-bit words) and data memory (32 bytes). On a START command it raises the CPU `start_i` input and then stops accepting input. It replaces simulation-only memory preloading, so the same binary can be brought up in hardware.

## Interface
Parameters:
- `IMEM_WORDS`, 256: instruction memory depth in words; address width is log2.
- `DMEM_BYTES`, 32: data memory depth in bytes; address width is log2.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `in_data_i` in 8: stream byte.
- `in_valid_i` in 1: byte valid.
- `in_ready_o` out 1: loader accepts the byte; a transfer happens when valid and ready are both high on a rising edge.
- `imem_we_o` out 1: one-cycle instruction-memory write strobe.
- `imem_addr_o` out 8: word index.
- `imem_data_o` out 32: word, little-endian assembled.
- `dmem_we_o` out 1: one-cycle data-memory write strobe.
- `dmem_addr_o` out 5: byte address.
- `dmem_data_o` out 8: byte.
- `start_o` out 1: CPU start; sticky once set.
- `err_o` out 1: sticky protocol error.
- `words_loaded_o` out 16: count of imem words written since reset; wraps at 2^16.

## Operation
- Frame: CMD, BASE, COUNT, payload, then [CSUM] when the checksum option is compiled in.
- CMD codes:
  - 0x01 LOAD_IMEM: BASE is a word index. COUNT N is 1..255 words, with 0 meaning 256. Payload is 4·N bytes, LSB first.
  - 0x02 LOAD_DMEM: BASE is a byte address. COUNT N is bytes, with 0 meaning 256. Payload is N bytes.
  - 0x03 START: a single byte with no BASE or COUNT.
- States:
  - IDLE: waiting for CMD.
  - BASE, COUNT.
  - DATA: payload bytes.
  - CSUM: only with the option compiled in.
  - RUN.
  - ERR.
- Transitions:
  - IDLE→BASE on CMD 0x01/0x02.
  - IDLE→RUN on 0x03.
  - IDLE→ERR on any other value.
  - BASE→COUNT→DATA, one byte each.
  - DATA→IDLE after the last payload byte, or DATA→CSUM.
  - CSUM→IDLE on match; CSUM→ERR on mismatch.
- Address arithmetic:
  - imem address = (BASE + word_index) mod IMEM_WORDS.
  - dmem address = (BASE + byte_index) mod DMEM_BYTES.
  - Wrap-around is legal and is not an error. A dmem COUNT above 32 overwrites earlier bytes of the same frame.
- RUN: `start_o`=1 and `in_ready_o`=0, held until reset.
- ERR: `err_o`=1 and `in_ready_o`=1. Bytes are drained and discarded, no memory writes occur, and `start_o` is never raised. Only reset exits ERR.
- Reset mid-frame: the partial word is discarded, memory contents are untouched, and the FSM returns to IDLE.

## Timing
- Reset values:
  - `in_ready_o`=0, `imem_we_o`=0, `dmem_we_o`=0, `start_o`=0, `err_o`=0, `words_loaded_o`=0.
  - Address and data outputs are 0.
  - FSM is in IDLE.
- `in_ready_o` is registered. It rises on the first rising edge after reset is released and stays 1 in every state except RUN. No backpressure is applied while loading.
- imem write:
  - `imem_we_o` pulses for exactly one cycle, in the cycle after the 4th byte of a word is accepted, with address and data stable in that cycle.
  - `words_loaded_o` increments in the same cycle.
- dmem write: `dmem_we_o` pulses in the cycle after each payload byte is accepted.
- Back-to-back bytes at one per cycle are supported, and so are back-to-back frames. The first byte of the next frame is accepted in the cycle the final write pulse is issued.
- START: `start_o` rises in the cycle after CMD 0x03 is accepted. `in_ready_o` falls in that same cycle.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - The frame carries a trailing CSUM byte equal to the sum of all payload bytes mod 256.
  - Writes are still issued as bytes arrive.
  - A mismatch enters ERR and sets `err_o` in the cycle after the CSUM byte is accepted.
- Not defined: there is no CSUM state or byte, and DATA returns directly to IDLE.

## Structure
- `prog_loader_pkg` holds:
  - the CMD code constants (`CMD_LOAD_IMEM`, `CMD_LOAD_DMEM`, `CMD_START`);
  - the FSM state enum;
  - the default depths.
- One sub-module, `byte_packer`, shifts 4 bytes into a 32-bit little-endian word and flags when the word is complete. It clears on reset or at the start of a frame.

## Test plan
- LOAD_IMEM base 0x00, count 2, bytes 13 00 00 00 93 00 10 00 → imem[0]=0x00000013, imem[1]=0x00100093, two single-cycle `imem_we_o` pulses, `words_loaded_o`=2.
- LOAD_DMEM base 0x1F, count 2, bytes 05 07 → dmem[31]=5, dmem[0]=7 (wrap), `err_o`=0.
- LOAD_IMEM then START, CPU in `start_i` path → `start_o`=1 one cycle after 0x03, `in_ready_o`=0, and further valid bytes cause no writes.
- CMD 0x7F → `err_o`=1, no write strobes, and a later 0x03 does not raise `start_o`.
- Reset asserted after the 2nd payload byte of a word → no `imem_we_o`, all outputs at reset values. After release, a fresh 1-word frame writes correctly.
- With `PROG_LOADER_CHECKSUM_EN`: dmem frame base 0, count 2, bytes 10 20, CSUM 0x30 → IDLE with `err_o`=0. The same frame with CSUM 0x31 → `err_o`=1.
